// File: rtl/ctlr_responder.sv
// Player-side emulation of the NES standard controller (4021 shift register).
// Synchronizes, debounces and turbo-gates board buttons, then serializes a latched snapshot.
module ctlr_responder #(
   parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
   parameter logic [23:0] TURBO_PERIOD    = 24'd400000
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       stall,
   input  logic       ctlr_latch,
   input  logic       ctlr_rd,
   input  logic [7:0] buttons_raw,
   input  logic [1:0] turbo_en,
   output logic       ctlr_data,
   output logic [7:0] buttons_db
);

   typedef enum logic [1:0] {
      ST_LATCHED   = 2'd0,
      ST_SHIFTING  = 2'd1,
      ST_EXHAUSTED = 2'd2
   } state_t;

   // A and B are suppressed during the off half of the turbo square wave.
   function automatic logic [7:0] apply_turbo(input logic [7:0] db,
                                              input logic [1:0] en,
                                              input logic       phase);
      logic [7:0] eff;
      eff    = db;
      eff[0] = db[0] & (~en[0] | phase);
      eff[1] = db[1] & (~en[1] | phase);
      return eff;
   endfunction

   logic [7:0]  sync1_q, sync2_q;
   logic [7:0]  prev_q;
   logic [7:0]  db_q, db_d;
   logic [15:0] db_cnt_q, db_cnt_d;
   logic [15:0] db_cnt_inc_s;
   logic [23:0] turbo_cnt_q, turbo_cnt_d;
   logic        turbo_phase_q, turbo_phase_d;
   state_t      state_q, state_d;
   logic [7:0]  shreg_q, shreg_d;
   logic [3:0]  bit_cnt_q, bit_cnt_d;
   logic        data_q, data_d;
   logic [7:0]  eff_s;

   // Two-flop synchronizer; keeps running through stall.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q <= 8'h00;
         sync2_q <= 8'h00;
      end else begin
         sync1_q <= buttons_raw;
         sync2_q <= sync1_q;
      end
   end

   // Debounce: the first cycle of a new synchronized value counts as stable cycle zero.
   always_comb begin
      db_d         = db_q;
      db_cnt_d     = db_cnt_q;
      db_cnt_inc_s = 16'd0;
      if (sync2_q != db_q) begin
         if (sync2_q != prev_q) begin
            db_cnt_inc_s = 16'd0;
         end else if (db_cnt_q == 16'hFFFF) begin
            db_cnt_inc_s = 16'hFFFF;
         end else begin
            db_cnt_inc_s = db_cnt_q + 16'd1;
         end
         if (db_cnt_inc_s == (DEBOUNCE_CYCLES - 16'd1)) begin
            db_d     = sync2_q;
            db_cnt_d = 16'd0;
         end else begin
            db_cnt_d = db_cnt_inc_s;
         end
      end else begin
         db_cnt_d = 16'd0;
      end
   end

   // Turbo square wave generator.
   always_comb begin
      turbo_cnt_d   = turbo_cnt_q;
      turbo_phase_d = turbo_phase_q;
      if (turbo_cnt_q >= (TURBO_PERIOD - 24'd1)) begin
         turbo_cnt_d   = 24'd0;
         turbo_phase_d = ~turbo_phase_q;
      end else begin
         turbo_cnt_d = turbo_cnt_q + 24'd1;
      end
   end

   assign eff_s = apply_turbo(db_q, turbo_en, turbo_phase_q);

   // Serial protocol FSM; a high latch level overrides every state and any read.
   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      bit_cnt_d = bit_cnt_q;
      if (ctlr_latch) begin
         state_d   = ST_LATCHED;
         shreg_d   = ~eff_s;
         bit_cnt_d = 4'd0;
      end else begin
         case (state_q)
            ST_LATCHED: begin
               state_d = ST_SHIFTING;
            end
            ST_SHIFTING: begin
               if (ctlr_rd) begin
                  shreg_d   = {1'b1, shreg_q[7:1]};
                  bit_cnt_d = bit_cnt_q + 4'd1;
                  if (bit_cnt_q == 4'd7) begin
                     state_d = ST_EXHAUSTED;
                  end else begin
                     state_d = ST_SHIFTING;
                  end
               end else begin
                  state_d = ST_SHIFTING;
               end
            end
            ST_EXHAUSTED: begin
               state_d = ST_EXHAUSTED;
            end
            default: begin
               state_d   = ST_EXHAUSTED;
               shreg_d   = 8'hFF;
               bit_cnt_d = 4'd0;
            end
         endcase
      end
      if (state_d == ST_EXHAUSTED) begin
         data_d = 1'b1;
      end else begin
         data_d = shreg_d[0];
      end
   end

   // Main state registers; stall freezes everything downstream of the synchronizer.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         prev_q        <= 8'h00;
         db_q          <= 8'h00;
         db_cnt_q      <= 16'd0;
         turbo_cnt_q   <= 24'd0;
         turbo_phase_q <= 1'b0;
         state_q       <= ST_EXHAUSTED;
         shreg_q       <= 8'hFF;
         bit_cnt_q     <= 4'd0;
         data_q        <= 1'b1;
      end else if (!stall) begin
         prev_q        <= sync2_q;
         db_q          <= db_d;
         db_cnt_q      <= db_cnt_d;
         turbo_cnt_q   <= turbo_cnt_d;
         turbo_phase_q <= turbo_phase_d;
         state_q       <= state_d;
         shreg_q       <= shreg_d;
         bit_cnt_q     <= bit_cnt_d;
         data_q        <= data_d;
      end else begin
         prev_q        <= prev_q;
         db_q          <= db_q;
         db_cnt_q      <= db_cnt_q;
         turbo_cnt_q   <= turbo_cnt_q;
         turbo_phase_q <= turbo_phase_q;
         state_q       <= state_q;
         shreg_q       <= shreg_q;
         bit_cnt_q     <= bit_cnt_q;
         data_q        <= data_q;
      end
   end

   assign ctlr_data  = data_q;
   assign buttons_db = db_q;

endmodule
